// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter: FSM encoding, error fill value
// and access-size codes seen on the memory side.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam logic [31:0] DEAD_VALUE = 32'hDEAD_BEEF;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; a tie goes to the requester not granted last.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    assign gnt_a = en && req_a && (!req_b || last_b);
    assign gnt_b = en && req_b && (!req_a || !last_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbitrates the I-refill and data ports onto main memory, one transfer at a time,
// with a read timeout that completes with an error and DEAD_VALUE.
module main_mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,

    output logic        mm_rden1,
    output logic        mm_rden2,
    output logic        mm_we2,
    output logic [13:0] mm_addr1,
    output logic [31:0] mm_addr2,
    output logic [31:0] mm_din2,
    output logic [1:0]  mm_size,
    output logic        mm_sign,
    output logic        mm_rst,
    input  logic [31:0] mm_dout1,
    input  logic [31:0] mm_dout2,
    input  logic        mm_valid1,
    input  logic        mm_valid2,

    output logic        gnt_i,
    output logic        gnt_d
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [1:0]       lat_size;
    logic             lat_sign;
    logic             lat_we;
    logic             owner_d;
    logic             err_flag;

    logic arb_en;
    logic arb_i;
    logic arb_d;
    logic busy_i;
    logic busy_d;
    logic in_done;
    logic timeout_hit;

    assign arb_en = (state == ST_IDLE) && !reset;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req_a (i_req),
        .req_b (d_req),
        .gnt_a (arb_i),
        .gnt_b (arb_d)
    );

    // Outputs are gated by reset so an aborted transfer never pulses valid/err.
    assign busy_i      = (state == ST_BUSY_I) && !reset;
    assign busy_d      = (state == ST_BUSY_D) && !reset;
    assign in_done     = (state == ST_DONE) && !reset;
    assign timeout_hit = (wait_cnt == CNT_LAST);

    assign gnt_i    = busy_i;
    assign gnt_d    = busy_d;
    assign mm_rden1 = busy_i;
    assign mm_rden2 = busy_d && !lat_we;
    assign mm_we2   = busy_d && lat_we;
    assign mm_rst   = reset || (state == ST_DONE);

    assign mm_addr1 = lat_addr[15:2];
    assign mm_addr2 = lat_addr;
    assign mm_din2  = lat_wdata;
    assign mm_size  = lat_size;
    assign mm_sign  = lat_sign;

    assign i_valid = in_done && !owner_d && !err_flag;
    assign i_err   = in_done && !owner_d && err_flag;
    assign d_valid = in_done && owner_d && !err_flag;
    assign d_err   = in_done && owner_d && err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
            lat_we    <= 1'b0;
            owner_d   <= 1'b0;
            err_flag  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_i) begin
                        state     <= ST_BUSY_I;
                        owner_d   <= 1'b0;
                        err_flag  <= 1'b0;
                        wait_cnt  <= '0;
                        lat_addr  <= i_addr;
                        lat_wdata <= '0;
                        lat_size  <= SIZE_WORD;
                        lat_sign  <= 1'b0;
                        lat_we    <= 1'b0;
                    end else if (arb_d) begin
                        state     <= ST_BUSY_D;
                        owner_d   <= 1'b1;
                        err_flag  <= 1'b0;
                        wait_cnt  <= '0;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_size  <= d_size;
                        lat_sign  <= d_sign;
                        lat_we    <= d_we;
                    end
                end
                ST_BUSY_I: begin
                    if (mm_valid1) begin
                        i_rdata <= mm_dout1;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        i_rdata  <= DEAD_VALUE;
                        err_flag <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_BUSY_D: begin
                    if (lat_we) begin
                        state <= ST_DONE;
                    end else if (mm_valid2) begin
                        d_rdata <= mm_dout2;
                        state   <= ST_DONE;
                    end else if (timeout_hit) begin
                        d_rdata  <= DEAD_VALUE;
                        err_flag <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: reset, round-robin tie, a table of single
// transfers (reads, writes, terminal-count success, timeouts) and reset mid-transfer.
module tb_main_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid, i_err;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic [31:0] d_rdata;
    logic        d_valid, d_err;
    logic        mm_rden1, mm_rden2, mm_we2;
    logic [13:0] mm_addr1;
    logic [31:0] mm_addr2, mm_din2;
    logic [1:0]  mm_size;
    logic        mm_sign, mm_rst;
    logic [31:0] mm_dout1, mm_dout2;
    logic        mm_valid1, mm_valid2;
    logic        gnt_i, gnt_d;

    int ncmp = 0;
    int nerr = 0;

    main_mem_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_sign(d_sign), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .mm_rden1(mm_rden1), .mm_rden2(mm_rden2), .mm_we2(mm_we2), .mm_addr1(mm_addr1),
        .mm_addr2(mm_addr2), .mm_din2(mm_din2), .mm_size(mm_size), .mm_sign(mm_sign),
        .mm_rst(mm_rst), .mm_dout1(mm_dout1), .mm_dout2(mm_dout2),
        .mm_valid1(mm_valid1), .mm_valid2(mm_valid2),
        .gnt_i(gnt_i), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sign;
        int          delay;      // BUSY cycle (1-based) carrying mm_valid; 0 = never
        logic [31:0] dout;
        int          exp_cycle;  // cycle of the completion pulse, request seen at cycle 0
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [13:0] exp_addr1;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  c;
        bit  seen;
        int  wecnt;
        string p;
        p = $sformatf("v%0d_", idx);
        i_req   = !v.is_d;
        d_req   = v.is_d;
        i_addr  = v.addr;
        d_addr  = v.addr;
        d_we    = v.we;
        d_wdata = v.wdata;
        d_size  = v.size;
        d_sign  = v.sign;
        mm_dout1 = v.dout;
        mm_dout2 = v.dout;
        c = 0;
        seen = 0;
        wecnt = 0;
        while (!seen && c < 200) begin
            if (c == 1) begin
                if (!v.is_d) begin
                    chk({p, "gnt_i"}, 32'(gnt_i), 32'd1);
                    chk({p, "rden1"}, 32'(mm_rden1), 32'd1);
                    chk({p, "addr1"}, 32'(mm_addr1), 32'(v.exp_addr1));
                end else begin
                    chk({p, "gnt_d"}, 32'(gnt_d), 32'd1);
                    chk({p, "addr2"}, mm_addr2, v.addr);
                    chk({p, "size"}, 32'(mm_size), 32'(v.size));
                    chk({p, "sign"}, 32'(mm_sign), 32'(v.sign));
                    if (v.we) chk({p, "din2"}, mm_din2, v.wdata);
                    else      chk({p, "rden2"}, 32'(mm_rden2), 32'd1);
                end
            end
            if (mm_we2) wecnt++;
            mm_valid1 = !v.is_d && v.delay != 0 && c == v.delay;
            mm_valid2 = v.is_d && !v.we && v.delay != 0 && c == v.delay;
            tick();
            c++;
            if (i_valid || i_err || d_valid || d_err) seen = 1;
        end
        mm_valid1 = 1'b0;
        mm_valid2 = 1'b0;
        chk({p, "completed"}, 32'(seen), 32'd1);
        chk({p, "cycle"}, 32'(c), 32'(v.exp_cycle));
        if (!v.is_d) begin
            chk({p, "i_valid"}, 32'(i_valid), 32'(!v.exp_err));
            chk({p, "i_err"}, 32'(i_err), 32'(v.exp_err));
            chk({p, "d_other"}, 32'({d_valid, d_err}), 32'd0);
            chk({p, "i_rdata"}, i_rdata, v.exp_rdata);
        end else begin
            chk({p, "d_valid"}, 32'(d_valid), 32'(!v.exp_err));
            chk({p, "d_err"}, 32'(d_err), 32'(v.exp_err));
            chk({p, "i_other"}, 32'({i_valid, i_err}), 32'd0);
            chk({p, "d_rdata"}, d_rdata, v.exp_rdata);
        end
        chk({p, "done_mm"}, 32'({mm_rst, mm_rden1, mm_rden2, mm_we2}), 32'b1000);
        if (v.is_d && v.we) chk({p, "we_cycles"}, 32'(wecnt), 32'd1);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        chk({p, "after_done"}, 32'({i_valid, i_err, d_valid, d_err, mm_rst}), 32'd0);
        if (!v.is_d) chk({p, "i_hold"}, i_rdata, v.exp_rdata);
        else         chk({p, "d_hold"}, d_rdata, v.exp_rdata);
    endtask

    initial begin
        logic [8:0] gi, gd, iv, dv;
        logic       seen_pulse;

        // {is_d, we, addr, wdata, size, sign, delay, dout, exp_cycle, exp_err, exp_rdata, exp_addr1}
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, SIZE_WORD, 1'b0, 8, 32'h1234_5678, 9, 1'b0, 32'h1234_5678, 14'h0010};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 0, 32'h0, 2, 1'b0, 32'h0D0D_0D0D, 14'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, SIZE_HALF, 1'b1, 1, 32'h0000_BEEF, 2, 1'b0, 32'h0000_BEEF, 14'h0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, SIZE_WORD, 1'b0, 3, 32'hA5A5_A5A5, 4, 1'b0, 32'hA5A5_A5A5, 14'h3FFF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0, SIZE_BYTE, 1'b0, 64, 32'h0000_0077, 65, 1'b0, 32'h0000_0077, 14'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, SIZE_WORD, 1'b1, 0, 32'h1111_1111, 65, 1'b1, 32'hDEAD_BEEF, 14'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, SIZE_WORD, 1'b0, 0, 32'h2222_2222, 65, 1'b1, 32'hDEAD_BEEF, 14'h048D};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0008, 32'h5555_AAAA, SIZE_BYTE, 1'b0, 0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, 14'h0};

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = '0; d_sign = 1'b0;
        mm_dout1 = '0; mm_dout2 = '0; mm_valid1 = 1'b0; mm_valid2 = 1'b0;
        tick();
        tick();
        chk("rst_mm_rst", 32'(mm_rst), 32'd1);
        chk("rst_bits", 32'({i_valid, i_err, d_valid, d_err, mm_rden1, mm_rden2, mm_we2, gnt_i, gnt_d}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_mm_rst", 32'(mm_rst), 32'd0);
        chk("idle_addr2", mm_addr2, 32'd0);

        // Tie after reset: I, then D, then I again with both requests held.
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_size = SIZE_WORD; d_sign = 1'b0;
        mm_dout1 = 32'h0101_0101;
        mm_dout2 = 32'h0D0D_0D0D;
        for (int c = 0; c < 9; c++) begin
            gi[c] = gnt_i;
            gd[c] = gnt_d;
            iv[c] = i_valid;
            dv[c] = d_valid;
            mm_valid1 = mm_rden1;
            mm_valid2 = mm_rden2;
            if (c == 8) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
        end
        mm_valid1 = 1'b0;
        mm_valid2 = 1'b0;
        chk("rr_gnt_i", 32'(gi), 32'b0_1000_0010);
        chk("rr_gnt_d", 32'(gd), 32'b0_0001_0000);
        chk("rr_i_valid", 32'(iv), 32'b1_0000_0100);
        chk("rr_d_valid", 32'(dv), 32'b0_0010_0000);
        chk("rr_i_rdata", i_rdata, 32'h0101_0101);
        chk("rr_d_rdata", d_rdata, 32'h0D0D_0D0D);
        chk("rr_idle", 32'({gnt_i, gnt_d, i_valid, d_valid}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during the third BUSY_I cycle aborts the read silently.
        i_req = 1'b1;
        i_addr = 32'h0000_0040;
        tick();
        tick();
        tick();
        chk("abort_busy", 32'({gnt_i, mm_rden1}), 32'b11);
        reset = 1'b1;
        i_req = 1'b0;
        tick();
        chk("abort_bits", 32'({i_valid, i_err, d_valid, d_err, mm_rden1, mm_rden2, mm_we2, gnt_i, gnt_d}), 32'd0);
        chk("abort_mm_rst", 32'(mm_rst), 32'd1);
        chk("abort_i_rdata", i_rdata, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        chk("abort_addr1", 32'(mm_addr1), 32'd0);
        reset = 1'b0;
        seen_pulse = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (i_valid || i_err || mm_rden1 || mm_rst) seen_pulse = 1'b1;
        end
        chk("abort_quiet", 32'(seen_pulse), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
